uart_tx_timp: RTL

Serial transmitter for the clock's current time: the outbound counterpart of the UART time-load receiver. On a start request it snapshots the counter's `ore`/`minute` and sends them as the 7-byte ASCII line "HH:MM\r\n", 8N1, LSB first. It sits beside `counter_timp` in `ceas_top`: its inputs come from the counter outputs, and its serial output drives the board's TX pin.

---
 rtl/ceas_pkg.sv | 32 +++
 rtl/uart_tx_byte.sv | 138 +++++++++++++
 rtl/uart_tx_timp.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ceas_pkg.sv
// Shared definitions for the clock's UART blocks: serializer states, ASCII
// constants for the "HH:MM\r\n" time line, and the default bit period.
package ceas_pkg;

  // 50 MHz system clock / 9600 baud
  localparam int unsigned CLKS_PER_BIT_DEF = 5208;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned BIT_W    = 3;
  localparam int unsigned IDX_W    = 3;

  // Index of the final byte (LF) of the 7-byte line
  localparam logic [IDX_W-1:0] LINE_LAST_IDX = 3'd6;

  localparam logic [BYTE_W-1:0] ASCII_ZERO  = 8'h30;
  localparam logic [BYTE_W-1:0] ASCII_COLON = 8'h3A;
  localparam logic [BYTE_W-1:0] ASCII_CR    = 8'h0D;
  localparam logic [BYTE_W-1:0] ASCII_LF    = 8'h0A;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } tx_state_e;

  // Width of a counter that spans 0..n-1 (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One-byte 8N1 serializer, LSB first.
// Ports:
//   clock, reset  : system clock, async active-high reset
//   load          : accept load_byte; honoured in IDLE and in the final cycle
//                   of the stop bit, so a caller can chain bytes with no gap
//   load_byte     : byte to transmit
//   o_tx_serial   : serial line (registered, idles high)
//   busy          : registered, high from the load edge until the last stop
//                   bit ends without a new load
//   byte_done     : combinational, high in the last cycle of the stop bit
module uart_tx_byte
  import ceas_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_byte,
  output logic              o_tx_serial,
  output logic              busy,
  output logic              byte_done
);

  localparam int unsigned         CNT_W    = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]    BIT_LAST = 3'd7;

  tx_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [BIT_W-1:0]   bit_q,   bit_d;
  logic [BYTE_W-1:0]  shift_q, shift_d;
  logic               tx_q,    tx_d;
  logic               busy_q,  busy_d;
  logic               baud_end_c;

  assign baud_end_c  = (cnt_q == CNT_LAST);
  // Kept outside the next-state block: the caller's load depends on it
  assign byte_done   = (state_q == STOP_BIT) && baud_end_c;
  assign o_tx_serial = tx_q;
  assign busy        = busy_q;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next state; tx_d is the line level for the cycle after this edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        if (load) begin
          state_d = START_BIT;
          shift_d = load_byte;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START_BIT: begin
        if (baud_end_c) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA_BITS;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Shift register: the next bit to drive is always shift_q[1]
      DATA_BITS: begin
        if (baud_end_c) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = STOP_BIT;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = {1'b0, shift_q[BYTE_W-1:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP_BIT: begin
        if (baud_end_c) begin
          cnt_d = '0;
          if (load) begin
            state_d = START_BIT;
            shift_d = load_byte;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/uart_tx_timp.sv
// Time-line transmitter: on start, snapshots ore/minute and sends
// "HH:MM\r\n" over an 8N1 serial line, bytes back to back.
// Ports:
//   clock, reset  : system clock, async active-high reset
//   ore, minute   : current time from the counter (binary)
//   start         : single-cycle request, taken only while busy is low
//   o_tx_serial   : serial line, idles high
//   busy          : high while the line is in flight
//   done          : one-cycle pulse as the final stop bit completes
module uart_tx_timp
  import ceas_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] ore,
  input  logic [5:0] minute,
  input  logic       start,
  output logic       o_tx_serial,
  output logic       busy,
  output logic       done
);

  // ASCII tens (units=0) or units (units=1) digit of v; no clamping
  function automatic logic [BYTE_W-1:0] bin2ascii(input logic [5:0] v,
                                                  input logic       units);
    logic [5:0] d;
    d = units ? (v % 6'd10) : (v / 6'd10);
    return ASCII_ZERO + BYTE_W'(d);
  endfunction

  // Byte idx of the line "HH:MM\r\n"
  function automatic logic [BYTE_W-1:0] line_byte(input logic [IDX_W-1:0] idx,
                                                  input logic [4:0]       h,
                                                  input logic [5:0]       m);
    logic [BYTE_W-1:0] b;
    unique case (idx)
      3'd0:    b = bin2ascii(6'(h), 1'b0);
      3'd1:    b = bin2ascii(6'(h), 1'b1);
      3'd2:    b = ASCII_COLON;
      3'd3:    b = bin2ascii(m, 1'b0);
      3'd4:    b = bin2ascii(m, 1'b1);
      3'd5:    b = ASCII_CR;
      default: b = ASCII_LF;
    endcase
    return b;
  endfunction

  logic [4:0]        ore_q, ore_d;
  logic [5:0]        min_q, min_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d;

  logic              ser_busy;
  logic              byte_done;
  logic              accept_c;
  logic              last_c;
  logic              reissue_c;
  logic              load_c;
  logic [IDX_W-1:0]  nxt_idx_c;
  logic [BYTE_W-1:0] load_byte_c;

  assign accept_c  = start && !ser_busy;
  assign last_c    = (idx_q == LINE_LAST_IDX);
  assign reissue_c = byte_done && !last_c;
  assign load_c    = accept_c || reissue_c;
  assign nxt_idx_c = idx_q + IDX_W'(1);

  // Byte 0 is launched on the capture edge itself, so it comes from the
  // live inputs; every later byte comes from the captured registers.
  assign load_byte_c = accept_c ? bin2ascii(6'(ore), 1'b0)
                                : line_byte(nxt_idx_c, ore_q, min_q);

  assign busy = ser_busy;
  assign done = done_q;

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .clock       (clock),
    .reset       (reset),
    .load        (load_c),
    .load_byte   (load_byte_c),
    .o_tx_serial (o_tx_serial),
    .busy        (ser_busy),
    .byte_done   (byte_done)
  );

  // Capture, sequencer and done registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ore_q  <= '0;
      min_q  <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      ore_q  <= ore_d;
      min_q  <= min_d;
      idx_q  <= idx_d;
      done_q <= done_d;
    end
  end

  // Byte-index sequencer: reload in the byte_done cycle keeps bytes gapless
  always_comb begin
    ore_d  = ore_q;
    min_d  = min_q;
    idx_d  = idx_q;
    done_d = 1'b0;
    if (accept_c) begin
      ore_d = ore;
      min_d = minute;
      idx_d = '0;
    end else if (reissue_c) begin
      idx_d = nxt_idx_c;
    end
    if (byte_done && last_c) begin
      done_d = 1'b1;
    end
  end

endmodule
